// File: rtl/sorted_block_serializer.sv
// sorted_block_serializer
// Consumer end of the 8-lane sort pipeline. Captures one sorted block
// (lane 0 = smallest) per blk_valid/blk_ready handshake into a DEPTH-entry
// buffer and streams the head block out one lane per cycle, ascending or
// descending as selected by the blk_desc bit captured with the block.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   blk_valid/blk_ready block input handshake (blk_ready = count < DEPTH)
//   blk_data, blk_desc  block lanes (lane i at [i*DATA_W +: DATA_W]) and order
//   s_valid/s_ready     output lane handshake
//   s_data, s_idx       current lane value and its position within the block
//   s_first, s_last     s_idx == 0 / s_idx == LANES-1
//   drop_err, drop_cnt  sticky drop flag and saturating drop counter
module sorted_block_serializer #(
  parameter int DATA_W = 8,
  parameter int LANES  = 8,
  parameter int DEPTH  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      blk_valid,
  output logic                      blk_ready,
  input  logic [LANES*DATA_W-1:0]   blk_data,
  input  logic                      blk_desc,
  output logic                      s_valid,
  input  logic                      s_ready,
  output logic [DATA_W-1:0]         s_data,
  output logic [$clog2(LANES)-1:0]  s_idx,
  output logic                      s_first,
  output logic                      s_last,
  output logic                      drop_err,
  output logic [7:0]                drop_cnt
);

  localparam int IDX_W = $clog2(LANES);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                 state, state_next;
  logic [CNT_W-1:0]       count, count_next;
  logic [PTR_W-1:0]       rd_ptr, rd_ptr_next;
  logic [PTR_W-1:0]       wr_ptr, wr_ptr_next;
  logic [IDX_W-1:0]       idx_next;
  logic                   drop_err_next;
  logic [7:0]             drop_cnt_next;

  logic [LANES*DATA_W-1:0] buf_data [DEPTH];
  logic                    buf_desc [DEPTH];

  logic                    push, drop, pop, last_pop;
  logic [LANES*DATA_W-1:0] head;
  logic                    head_desc;
  logic [IDX_W-1:0]        lane_sel;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (DEPTH == 1) return '0;
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready depends only on the registered count, so a final pop does not
  // open the input in the same cycle.
  assign blk_ready = (count < CNT_W'(DEPTH));
  assign push      = blk_valid & blk_ready;
  assign drop      = blk_valid & ~blk_ready;
  assign pop       = s_valid & s_ready;
  assign last_pop  = pop & (s_idx == IDX_W'(LANES - 1));

  assign head      = buf_data[rd_ptr];
  assign head_desc = buf_desc[rd_ptr];
  assign lane_sel  = head_desc ? (IDX_W'(LANES - 1) - s_idx) : s_idx;

  assign s_first   = (s_idx == '0);
  assign s_last    = (s_idx == IDX_W'(LANES - 1));

  always_comb begin
    state_next    = state;
    count_next    = count;
    rd_ptr_next   = rd_ptr;
    wr_ptr_next   = wr_ptr;
    idx_next      = s_idx;
    drop_err_next = drop_err;
    drop_cnt_next = drop_cnt;
    s_valid       = 1'b0;
    s_data        = '0;

    case (state)
      IDLE:   s_valid = 1'b0;
      STREAM: begin
        s_valid = 1'b1;
        s_data  = head[lane_sel*DATA_W +: DATA_W];
      end
      default: s_valid = 1'b0;
    endcase

    if (push) wr_ptr_next = ptr_inc(wr_ptr);

    if (drop) begin
      drop_err_next = 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt_next = drop_cnt + 8'd1;
    end

    if (pop) begin
      idx_next = s_idx + 1'b1;
      if (last_pop) begin
        idx_next    = '0;
        rd_ptr_next = ptr_inc(rd_ptr);
      end
    end

    case ({push, last_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase

    state_next = (count_next != '0) ? STREAM : IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      s_idx    <= '0;
      drop_err <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      rd_ptr   <= rd_ptr_next;
      wr_ptr   <= wr_ptr_next;
      s_idx    <= idx_next;
      drop_err <= drop_err_next;
      drop_cnt <= drop_cnt_next;
    end
  end

  // Storage needs no reset: contents are only visible while STREAM.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      buf_data[wr_ptr] <= blk_data;
      buf_desc[wr_ptr] <= blk_desc;
    end
  end

endmodule

// File: tb/tb_sorted_block_serializer.sv
// Directed testbench for sorted_block_serializer. Expected lanes are queued
// when a block is offered that should be accepted; a negedge monitor pops
// and compares every lane the DUT hands off.
module tb_sorted_block_serializer;

  localparam int DATA_W = 8;
  localparam int LANES  = 8;
  localparam int DEPTH  = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     blk_valid;
  logic                     blk_ready;
  logic [LANES*DATA_W-1:0]  blk_data;
  logic                     blk_desc;
  logic                     s_valid;
  logic                     s_ready;
  logic [DATA_W-1:0]        s_data;
  logic [$clog2(LANES)-1:0] s_idx;
  logic                     s_first;
  logic                     s_last;
  logic                     drop_err;
  logic [7:0]               drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];   // idx*256 + data

  always #5 clk = ~clk;

  sorted_block_serializer #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_data(blk_data), .blk_desc(blk_desc),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_idx(s_idx),
    .s_first(s_first), .s_last(s_last),
    .drop_err(drop_err), .drop_cnt(drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lane handoff monitor.
  always @(negedge clk) begin
    if (!rst && s_valid === 1'b1 && s_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_lane", {24'd0, s_data}, 32'hFFFF_FFFF);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("lane_data",  {24'd0, s_data}, e & 255);
        check("lane_idx",   {29'd0, s_idx}, e >> 8);
        check("lane_first", {31'd0, s_first}, ((e >> 8) == 0) ? 1 : 0);
        check("lane_last",  {31'd0, s_last}, ((e >> 8) == LANES - 1) ? 1 : 0);
      end
    end
  end

  function automatic logic [7:0] lane_val(input logic [7:0] base, input logic [7:0] step, input int i);
    logic [7:0] v;
    v = base + step * 8'(i);
    return v;
  endfunction

  task automatic send_block(input logic [7:0] base, input logic [7:0] step,
                            input logic desc, input bit accept);
    for (int i = 0; i < LANES; i++) blk_data[i*DATA_W +: DATA_W] = lane_val(base, step, i);
    blk_desc  = desc;
    blk_valid = 1'b1;
    if (accept) begin
      for (int k = 0; k < LANES; k++)
        exp_q.push_back(k * 256 + int'(lane_val(base, step, desc ? (LANES - 1 - k) : k)));
    end
    tick();
    blk_valid = 1'b0;
  endtask

  task automatic drain(output int n);
    bit done;
    n = 0;
    done = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (exp_q.size() == 0 && s_valid == 1'b0) begin
        done = 1'b1;
        break;
      end
      tick();
      n++;
    end
    check("drain_done", {31'd0, done}, 1);
  endtask

  initial begin
    int n;

    // T1: reset with garbage on the inputs
    rst       = 1'b1;
    blk_valid = 1'b1;
    blk_data  = {$urandom(), $urandom()};
    blk_desc  = 1'b1;
    s_ready   = 1'b1;
    tick(); tick(); tick();
    rst       = 1'b0;
    blk_valid = 1'b0;
    #1;
    check("rst_s_valid",   {31'd0, s_valid}, 0);
    check("rst_s_data",    {24'd0, s_data}, 0);
    check("rst_s_idx",     {29'd0, s_idx}, 0);
    check("rst_drop_err",  {31'd0, drop_err}, 0);
    check("rst_drop_cnt",  {24'd0, drop_cnt}, 0);
    check("rst_blk_ready", {31'd0, blk_ready}, 1);

    // T2: ascending block, one-cycle latency, 8 lanes then idle
    s_ready = 1'b1;
    send_block(8'd1, 8'd1, 1'b0, 1'b1);
    check("t2_latency_valid", {31'd0, s_valid}, 1);
    check("t2_first_data",    {24'd0, s_data}, 1);
    check("t2_first_flag",    {31'd0, s_first}, 1);
    drain(n);
    check("t2_lane_cycles", n, 8);
    check("t2_idle_after",  {31'd0, s_valid}, 0);

    // T3: descending block with backpressure at idx 2
    send_block(8'd10, 8'd10, 1'b1, 1'b1);
    tick(); tick();
    s_ready = 1'b0;
    for (int h = 0; h < 3; h++) begin
      check("t3_hold_data", {24'd0, s_data}, 60);
      check("t3_hold_idx",  {29'd0, s_idx}, 2);
      tick();
    end
    s_ready = 1'b1;
    drain(n);
    check("t3_idle_after", {31'd0, s_valid}, 0);

    // T4: back-to-back blocks stream as 16 contiguous lanes
    send_block(8'h21, 8'd3, 1'b0, 1'b1);
    send_block(8'h80, 8'd5, 1'b1, 1'b1);
    drain(n);
    check("t4_contiguous", n, 15);

    // T5: overflow while stalled, then saturating drop counter
    s_ready = 1'b0;
    send_block(8'h40, 8'd1, 1'b0, 1'b1);
    check("t5_ready_after_1", {31'd0, blk_ready}, 1);
    send_block(8'h90, 8'd2, 1'b1, 1'b1);
    check("t5_ready_after_2", {31'd0, blk_ready}, 0);
    for (int i = 0; i < LANES; i++) blk_data[i*DATA_W +: DATA_W] = 8'hEE;
    blk_valid = 1'b1;
    for (int d = 1; d <= 300; d++) begin
      tick();
      if (d == 1) begin
        check("t5_drop_err",   {31'd0, drop_err}, 1);
        check("t5_drop_cnt1",  {24'd0, drop_cnt}, 1);
        check("t5_head_intact", {24'd0, s_data}, 8'h40);
      end
      if (d == 254) check("t5_drop_cnt254", {24'd0, drop_cnt}, 254);
      if (d == 255) check("t5_drop_cnt255", {24'd0, drop_cnt}, 255);
    end
    check("t5_drop_sat", {24'd0, drop_cnt}, 255);
    blk_valid = 1'b0;
    s_ready   = 1'b1;
    drain(n);
    check("t5_drain_cycles", n, 16);

    // T6: reset at idx 4 with a second block queued
    send_block(8'hA0, 8'd1, 1'b0, 1'b1);
    send_block(8'hC0, 8'd1, 1'b1, 1'b1);
    tick(); tick(); tick();
    check("t6_idx_before_rst", {29'd0, s_idx}, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("t6_s_valid",   {31'd0, s_valid}, 0);
    check("t6_blk_ready", {31'd0, blk_ready}, 1);
    check("t6_s_idx",     {29'd0, s_idx}, 0);
    check("t6_drop_err",  {31'd0, drop_err}, 0);
    check("t6_drop_cnt",  {24'd0, drop_cnt}, 0);
    for (int w = 0; w < 3; w++) begin
      tick();
      check("t6_stays_idle", {31'd0, s_valid}, 0);
    end
    send_block(8'd5, 8'd7, 1'b0, 1'b1);
    check("t6_new_valid", {31'd0, s_valid}, 1);
    check("t6_new_idx",   {29'd0, s_idx}, 0);
    check("t6_new_data",  {24'd0, s_data}, 5);
    drain(n);
    check("t6_new_cycles", n, 8);

    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
